// File: rtl/cache_ctrl.sv
// 2-way, 4-set, one-word-per-block write-through cache controller between the MEM stage and main memory.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_ctrl #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned SET_BITS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   input  logic              flush,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef CACHE_STATS_EN
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt,
`endif
   input  logic              mem_ack
);

   localparam int unsigned SETS  = 1 << SET_BITS;
   localparam int unsigned TAG_W = ADDR_W - SET_BITS;

   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE_MEM, FLUSH} state_t;

   state_t                          state;
   logic                            we_q;
   logic [ADDR_W-1:0]               addr_q;
   logic [DATA_W-1:0]               wdata_q;
   logic [SET_BITS-1:0]             fl_set;
   logic [SETS-1:0][1:0]            valid;
   logic [SETS-1:0]                 lru;
   logic [TAG_W-1:0]                tags  [SETS][2];
   logic [DATA_W-1:0]               blocks[SETS][2];

   logic [SET_BITS-1:0]             set;
   logic [TAG_W-1:0]                tag;
   logic                            hit0, hit1, hit, hit_way, victim;

   // Lookup of the latched request against both ways of its set
   always_comb begin
      set     = addr_q[SET_BITS-1:0];
      tag     = addr_q[ADDR_W-1:SET_BITS];
      hit0    = valid[set][0] && (tags[set][0] == tag);
      hit1    = valid[set][1] && (tags[set][1] == tag);
      hit     = hit0 || hit1;
      hit_way = hit1;
      // lru bit names the way to evict next once both ways hold data
      if (!valid[set][0])      victim = 1'b0;
      else if (!valid[set][1]) victim = 1'b1;
      else                     victim = lru[set];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cpu_done  <= 1'b0;
         cpu_rdata <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         fl_set    <= '0;
         valid     <= '0;
         lru       <= '0;
`ifdef CACHE_STATS_EN
         hit_cnt   <= '0;
         miss_cnt  <= '0;
`endif
      end else begin
         cpu_done <= 1'b0;
         case (state)
            IDLE: begin
               if (flush) begin
                  fl_set <= '0;
                  state  <= FLUSH;
               end else if (cpu_req) begin
                  we_q    <= cpu_we;
                  addr_q  <= cpu_addr;
                  wdata_q <= cpu_wdata;
                  state   <= LOOKUP;
               end
            end
            LOOKUP: begin
`ifdef CACHE_STATS_EN
               if (hit && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
               if (!hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
`endif
               if (hit) lru[set] <= ~hit_way;
               if (hit && !we_q) begin
                  cpu_rdata <= blocks[set][hit_way];
                  cpu_done  <= 1'b1;
                  state     <= IDLE;
               end else if (we_q) begin
                  // write-through; misses do not allocate
                  if (hit) blocks[set][hit_way] <= wdata_q;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= addr_q;
                  mem_wdata <= wdata_q;
                  state     <= WRITE_MEM;
               end else begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= addr_q;
                  state    <= FILL;
               end
            end
            FILL: begin
               if (mem_ack) begin
                  blocks[set][victim] <= mem_rdata;
                  tags[set][victim]   <= tag;
                  valid[set][victim]  <= 1'b1;
                  lru[set]            <= ~victim;
                  cpu_rdata           <= mem_rdata;
                  cpu_done            <= 1'b1;
                  mem_req             <= 1'b0;
                  state               <= IDLE;
               end
            end
            WRITE_MEM: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  cpu_done <= 1'b1;
                  state    <= IDLE;
               end
            end
            FLUSH: begin
               valid[fl_set] <= 2'b00;
               lru[fl_set]   <= 1'b0;
               fl_set        <= fl_set + 1'b1;
               if (fl_set == '1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed and randomized bench for cache_ctrl against an LRU-list reference model of the cache.
module tb_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, flush, mem_ack;
   logic [7:0]  cpu_addr;
   logic [15:0] cpu_wdata, mem_rdata;
   logic [15:0] cpu_rdata, mem_wdata;
   logic [7:0]  mem_addr;
   logic        cpu_done, mem_req, mem_we;
`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt, miss_cnt;
`endif

   cache_ctrl dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
`ifdef CACHE_STATS_EN
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
      .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: backing memory plus, per set, resident addresses ordered most-recent first
   logic [15:0] mem [256];
   logic [7:0]  res_q [4][$];
   int          hits, misses;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int s = 0; s < 4; s++) res_q[s].delete();
   endtask

   task automatic model_op(input logic we, input logic [7:0] a, input logic [15:0] wd, output logic hit);
      int s;
      int idx;
      s   = int'(a[1:0]);
      idx = -1;
      for (int i = 0; i < res_q[s].size(); i++) if (res_q[s][i] == a) idx = i;
      hit = (idx >= 0);
      if (hit) begin
         res_q[s].delete(idx);
         res_q[s].push_front(a);
      end else if (!we) begin
         res_q[s].push_front(a);
         if (res_q[s].size() > 2) void'(res_q[s].pop_back());
      end
      if (hit) begin if (hits < 65535) hits++; end
      else     begin if (misses < 65535) misses++; end
      if (we) mem[a] = wd;
   endtask

   task automatic check_stats();
`ifdef CACHE_STATS_EN
      check("hit_cnt", 32'(hit_cnt), 32'(hits));
      check("miss_cnt", 32'(miss_cnt), 32'(misses));
`endif
   endtask

   // One CPU transaction from the IDLE sample point; memory answers dly cycles after mem_req rises
   task automatic run_op(input logic we, input logic [7:0] a, input logic [15:0] wd,
                         input int dly, input bit with_flush);
      logic        hit, exp_mem;
      bit          done, seen;
      int          req_c, done_c, wt, hold, hold_err, exp_done_c;
      logic [7:0]  ma;
      logic        mwe, req_at_done;
      logic [15:0] mwd, rd, last;
      done = 0; seen = 0; req_c = -1; done_c = -1; wt = 0; hold_err = 0;
      ma = '0; mwe = 1'b0; mwd = '0; rd = '0; req_at_done = 1'b0;
      hold = with_flush ? 5 : 0;
      if (with_flush) model_clear();
      model_op(we, a, wd, hit);
      cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1; flush = with_flush;
      last = cpu_rdata;
      for (int c = 0; c < 80 && !done; c++) begin
         @(posedge clk); #1;
         flush     = 1'b0;
         mem_ack   = 1'b0;
         mem_rdata = 16'($urandom);
         if (c == hold) begin
            cpu_req   = 1'b0;
            cpu_we    = 1'($urandom);
            cpu_addr  = 8'($urandom);
            cpu_wdata = 16'($urandom);
         end
         if (cpu_done) begin
            done = 1; done_c = c; rd = cpu_rdata; req_at_done = mem_req;
         end else begin
            if (cpu_rdata !== last) hold_err++;
            if (mem_req && !seen) begin
               seen = 1; req_c = c; ma = mem_addr; mwe = mem_we; mwd = mem_wdata; wt = dly;
            end
            if (seen && mem_req) begin
               if (wt == 0) begin
                  mem_ack = 1'b1;
                  if (!mwe) mem_rdata = mem[ma];
               end
               wt--;
            end
         end
      end
      mem_ack = 1'b0;
      exp_mem    = !(hit && !we);
      exp_done_c = exp_mem ? hold + 2 + dly : hold + 1;
      check("done_seen", 32'(done), 32'd1);
      check("done_cycle", 32'(done_c), 32'(exp_done_c));
      check("mem_req_seen", 32'(seen), 32'(exp_mem));
      if (exp_mem && seen) begin
         check("mem_req_cycle", 32'(req_c), 32'(hold + 1));
         check("mem_addr", 32'(ma), 32'(a));
         check("mem_we", 32'(mwe), 32'(we));
         if (we) check("mem_wdata", 32'(mwd), 32'(wd));
      end
      if (!we) check("cpu_rdata", 32'(rd), 32'(mem[a]));
      check("mem_req_low_at_done", 32'(req_at_done), 32'd0);
      check("rdata_hold", 32'(hold_err), 32'd0);
      check_stats();
   endtask

   initial begin
      logic [7:0] ra;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[8'h05] = 16'hBEEF;
      hits = 0; misses = 0;
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; flush = 1'b0; mem_ack = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_cpu_done", 32'(cpu_done), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check_stats();

      // Cold read miss, then the same word hits
      run_op(1'b0, 8'h05, 16'h0, 3, 1'b0);
      check("first_read_data", 32'(cpu_rdata), 32'h0000BEEF);
      run_op(1'b0, 8'h05, 16'h0, 3, 1'b0);
      check("reread_data", 32'(cpu_rdata), 32'h0000BEEF);

      // LRU replacement in set 1: 0x01 becomes the victim once 0x05 is touched
      run_op(1'b0, 8'h01, 16'h0, 1, 1'b0);
      run_op(1'b0, 8'h05, 16'h0, 1, 1'b0);
      run_op(1'b0, 8'h0D, 16'h0, 2, 1'b0);
      run_op(1'b0, 8'h05, 16'h0, 1, 1'b0);
      run_op(1'b0, 8'h01, 16'h0, 0, 1'b0);

      // Write hit updates cache and memory; write miss does not allocate
      run_op(1'b1, 8'h05, 16'h1234, 2, 1'b0);
      run_op(1'b0, 8'h05, 16'h0, 2, 1'b0);
      check("write_hit_readback", 32'(cpu_rdata), 32'h00001234);
      run_op(1'b1, 8'h22, 16'hA5A5, 0, 1'b0);
      run_op(1'b0, 8'h22, 16'h0, 0, 1'b0);

      // Flush with a simultaneous request: flush first, then the request misses
      run_op(1'b0, 8'h05, 16'h0, 1, 1'b1);

      // Randomized mix over a small address range to exercise hits and evictions
      for (int n = 0; n < 150; n++) begin
         ra = 8'($urandom_range(0, 23));
         run_op(1'($urandom_range(0, 2) == 0), ra, 16'($urandom), $urandom_range(0, 4),
                $urandom_range(0, 19) == 0);
      end

      // Reset during FILL drops the request and ignores the late ack
      cpu_we = 1'b0; cpu_addr = 8'h40; cpu_req = 1'b1;
      @(posedge clk); #1 cpu_req = 1'b0;
      @(posedge clk); #1;
      check("fill_before_rst", 32'(mem_req), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("rst_mid_mem_req", 32'(mem_req), 32'd0);
      check("rst_mid_done", 32'(cpu_done), 32'd0);
      model_clear(); hits = 0; misses = 0;
      check_stats();
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1 mem_ack = 1'b0;
         check("late_ack_done", 32'(cpu_done), 32'd0);
         check("late_ack_mem_req", 32'(mem_req), 32'd0);
      end
      run_op(1'b0, 8'h05, 16'h0, 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
